// File: rtl/calc_op_sequencer.sv
// ---------------------------------------------------------------------------
// calc_op_sequencer
//   Key-entry controller for the calculator ALU. Builds two decimal operands
//   and an opcode from 4-bit key codes, launches the ALU with a start/done
//   handshake, then holds the result or the error for the output mux.
//
// Optional feature macro: CALC_SEQ_TIMEOUT_EN
//   When defined, WAIT gives up after TIMEOUT_CYC cycles without alu_done
//   and enters ERROR with err_code 3. When undefined, WAIT has no limit.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          synchronous reset, active-high
//   i_key_valid    key code valid this cycle
//   i_key_code     0-9 digit, 10 '+', 11 '-', 12 '*', 13 '/', 14 '=', 15 clear
//   o_key_ready    key accepted when i_key_valid && o_key_ready
//   o_alu_start    one-cycle ALU launch pulse
//   o_alu_op       0 add, 1 sub, 2 mul, 3 div
//   o_alu_a/b      ALU operands
//   i_alu_done     ALU result valid pulse
//   i_alu_result   ALU result, sampled with i_alu_done
//   i_alu_err      ALU error, sampled with i_alu_done
//   o_result       displayed value
//   o_result_valid o_result holds a completed computation
//   o_err          sequencer is in ERROR
//   o_err_code     0 none, 1 entry overflow, 2 ALU error, 3 timeout
//   o_busy         high in LAUNCH and WAIT
//   o_state_dbg    current state encoding
//
// State    | meaning
// ENTER_A  | entering operand A (result mirrors A)
// ENTER_B  | operator latched, entering operand B (result mirrors B)
// LAUNCH   | one-cycle alu_start pulse
// WAIT     | waiting for alu_done
// SHOW     | completed result on display
// ERROR    | entry overflow / ALU error / timeout; only clear leaves
// ---------------------------------------------------------------------------
module calc_op_sequencer #(
    parameter int WIDTH       = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_key_valid,
    input  logic [3:0]       i_key_code,
    output logic             o_key_ready,
    output logic             o_alu_start,
    output logic [1:0]       o_alu_op,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    input  logic             i_alu_done,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_err,
    output logic [WIDTH-1:0] o_result,
    output logic             o_result_valid,
    output logic             o_err,
    output logic [1:0]       o_err_code,
    output logic             o_busy,
    output logic [2:0]       o_state_dbg
);

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_SHOW    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    // Accumulator math is done 4 bits wider so acc*10+9 never wraps.
    localparam int AW = WIDTH + 4;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, w_a_nxt;
    logic [WIDTH-1:0] r_b, w_b_nxt;
    logic [1:0]       r_op, w_op_nxt;
    logic             r_b_seen, w_b_seen_nxt;
    logic [WIDTH-1:0] r_res, w_res_nxt;
    logic [1:0]       r_err_code, w_err_code_nxt;

    logic             w_accept;
    logic             w_is_digit;
    logic             w_is_op;
    logic             w_is_eq;
    logic             w_is_clr;
    logic [1:0]       w_op_code;
    logic [WIDTH-1:0] w_acc_src;
    logic [AW-1:0]    w_acc_ext;
    logic             w_acc_ovf;

`ifdef CALC_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
`endif

    assign w_accept   = i_key_valid && o_key_ready;
    assign w_is_digit = (i_key_code <= 4'd9);
    assign w_is_op    = (i_key_code >= 4'd10) && (i_key_code <= 4'd13);
    assign w_is_eq    = (i_key_code == 4'd14);
    assign w_is_clr   = (i_key_code == 4'd15);
    assign w_op_code  = 2'(i_key_code - 4'd10);

    assign w_acc_src = (r_state == ST_ENTER_B) ? r_b : r_a;
    assign w_acc_ext = ({4'b0000, w_acc_src} * AW'(10)) + AW'(i_key_code);
    assign w_acc_ovf = |w_acc_ext[AW-1:WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_ENTER_A;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_b_seen   <= 1'b0;
            r_res      <= '0;
            r_err_code <= '0;
`ifdef CALC_SEQ_TIMEOUT_EN
            r_tmo_cnt  <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_op       <= w_op_nxt;
            r_b_seen   <= w_b_seen_nxt;
            r_res      <= w_res_nxt;
            r_err_code <= w_err_code_nxt;
`ifdef CALC_SEQ_TIMEOUT_EN
            r_tmo_cnt  <= w_tmo_cnt_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_op_nxt       = r_op;
        w_b_seen_nxt   = r_b_seen;
        w_res_nxt      = r_res;
        w_err_code_nxt = r_err_code;
`ifdef CALC_SEQ_TIMEOUT_EN
        w_tmo_cnt_nxt  = r_tmo_cnt;
`endif
        unique case (r_state)
            ST_ENTER_A: begin
                if (w_accept) begin
                    if (w_is_digit) begin
                        if (w_acc_ovf) begin
                            w_state_nxt    = ST_ERROR;
                            w_err_code_nxt = 2'd1;
                        end else begin
                            w_a_nxt = w_acc_ext[WIDTH-1:0];
                        end
                    end else if (w_is_op) begin
                        w_op_nxt     = w_op_code;
                        w_b_nxt      = '0;
                        w_b_seen_nxt = 1'b0;
                        w_state_nxt  = ST_ENTER_B;
                    end else if (w_is_eq) begin
                        w_res_nxt   = r_a;
                        w_state_nxt = ST_SHOW;
                    end else begin
                        w_a_nxt = '0;
                    end
                end
            end
            ST_ENTER_B: begin
                if (w_accept) begin
                    if (w_is_digit) begin
                        if (w_acc_ovf) begin
                            w_state_nxt    = ST_ERROR;
                            w_err_code_nxt = 2'd1;
                        end else begin
                            w_b_nxt      = w_acc_ext[WIDTH-1:0];
                            w_b_seen_nxt = 1'b1;
                        end
                    end else if (w_is_op) begin
                        // Operator after B digits is dropped; before them it replaces.
                        if (!r_b_seen) begin
                            w_op_nxt = w_op_code;
                        end
                    end else if (w_is_eq) begin
                        w_state_nxt = ST_LAUNCH;
                    end else begin
                        w_a_nxt      = '0;
                        w_b_nxt      = '0;
                        w_op_nxt     = '0;
                        w_b_seen_nxt = 1'b0;
                        w_res_nxt    = '0;
                        w_state_nxt  = ST_ENTER_A;
                    end
                end
            end
            ST_LAUNCH: begin
                w_state_nxt = ST_WAIT;
`ifdef CALC_SEQ_TIMEOUT_EN
                w_tmo_cnt_nxt = TW'(TIMEOUT_CYC - 1);
`endif
            end
            ST_WAIT: begin
                if (i_alu_done) begin
                    if (i_alu_err) begin
                        w_state_nxt    = ST_ERROR;
                        w_err_code_nxt = 2'd2;
                    end else begin
                        w_res_nxt   = i_alu_result;
                        w_state_nxt = ST_SHOW;
                    end
                end
`ifdef CALC_SEQ_TIMEOUT_EN
                else if (r_tmo_cnt == '0) begin
                    w_state_nxt    = ST_ERROR;
                    w_err_code_nxt = 2'd3;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt - 1'b1;
                end
`endif
            end
            ST_SHOW: begin
                if (w_accept) begin
                    if (w_is_op) begin
                        w_a_nxt      = r_res;
                        w_op_nxt     = w_op_code;
                        w_b_nxt      = '0;
                        w_b_seen_nxt = 1'b0;
                        w_state_nxt  = ST_ENTER_B;
                    end else if (w_is_digit) begin
                        w_a_nxt      = WIDTH'(i_key_code);
                        w_b_nxt      = '0;
                        w_b_seen_nxt = 1'b0;
                        w_state_nxt  = ST_ENTER_A;
                    end else if (w_is_clr) begin
                        w_a_nxt      = '0;
                        w_b_nxt      = '0;
                        w_op_nxt     = '0;
                        w_b_seen_nxt = 1'b0;
                        w_res_nxt    = '0;
                        w_state_nxt  = ST_ENTER_A;
                    end
                end
            end
            ST_ERROR: begin
                if (w_accept && w_is_clr) begin
                    w_a_nxt        = '0;
                    w_b_nxt        = '0;
                    w_op_nxt       = '0;
                    w_b_seen_nxt   = 1'b0;
                    w_res_nxt      = '0;
                    w_err_code_nxt = 2'd0;
                    w_state_nxt    = ST_ENTER_A;
                end
            end
            default: begin
                w_state_nxt = ST_ENTER_A;
            end
        endcase
    end

    always_comb begin
        o_key_ready    = 1'b1;
        o_alu_start    = 1'b0;
        o_busy         = 1'b0;
        o_result_valid = 1'b0;
        o_err          = 1'b0;
        o_result       = r_res;
        unique case (r_state)
            ST_ENTER_A: o_result = r_a;
            ST_ENTER_B: o_result = r_b;
            ST_LAUNCH: begin
                o_key_ready = 1'b0;
                o_alu_start = 1'b1;
                o_busy      = 1'b1;
                o_result    = r_b;
            end
            ST_WAIT: begin
                o_key_ready = 1'b0;
                o_busy      = 1'b1;
                o_result    = r_b;
            end
            ST_SHOW: o_result_valid = 1'b1;
            ST_ERROR: begin
                o_err    = 1'b1;
                o_result = '0;
            end
            default: o_result = '0;
        endcase
    end

    // Operands only change on accepted keys, which are blocked in LAUNCH/WAIT.
    assign o_alu_a     = r_a;
    assign o_alu_b     = r_b;
    assign o_alu_op    = r_op;
    assign o_err_code  = r_err_code;
    assign o_state_dbg = r_state;

endmodule

// File: tb/tb_calc_op_sequencer.sv
module tb_calc_op_sequencer;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
    } launch_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       alu_start;
    logic [1:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_done;
    logic [7:0] alu_result;
    logic       alu_err;
    logic [7:0] result;
    logic       result_valid;
    logic       err;
    logic [1:0] err_code;
    logic       busy;
    logic [2:0] state_dbg;

    int vectors = 0;
    int miscompares = 0;
    launch_t exp_q[$];
    launch_t got;

    always #5 clk = ~clk;

    calc_op_sequencer #(.WIDTH(8), .TIMEOUT_CYC(15)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_key_valid(key_valid), .i_key_code(key_code), .o_key_ready(key_ready),
        .o_alu_start(alu_start), .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b),
        .i_alu_done(alu_done), .i_alu_result(alu_result), .i_alu_err(alu_err),
        .o_result(result), .o_result_valid(result_valid), .o_err(err),
        .o_err_code(err_code), .o_busy(busy), .o_state_dbg(state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input int st, input int rv, input int res);
        chk({tag, ".state"}, 32'(state_dbg), st);
        chk({tag, ".rv"}, 32'(result_valid), rv);
        chk({tag, ".result"}, 32'(result), res);
    endtask

    // Reference ALU used to produce the bench's expected results.
    task automatic alu_model(input launch_t l, output logic [7:0] r, output logic e);
        int v;
        e = 1'b0;
        case (l.op)
            2'd0: v = int'(l.a) + int'(l.b);
            2'd1: v = (int'(l.a) - int'(l.b)) & 255;
            2'd2: v = int'(l.a) * int'(l.b);
            default: begin
                if (l.b == 0) begin v = 0; e = 1'b1; end
                else v = int'(l.a) / int'(l.b);
            end
        endcase
        if (v > 255) e = 1'b1;
        r = 8'(v);
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Returns at the negedge of the LAUNCH cycle.
    task automatic expect_launch(input string tag, output launch_t g);
        bit seen;
        launch_t e;
        seen = 1'b0;
        g = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (alu_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, ".start"}, 32'(seen), 1);
        chk({tag, ".sb_nonempty"}, 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = e;
            if (seen) begin
                chk({tag, ".a"}, 32'(alu_a), 32'(e.a));
                chk({tag, ".b"}, 32'(alu_b), 32'(e.b));
                chk({tag, ".op"}, 32'(alu_op), 32'(e.op));
                chk({tag, ".busy"}, 32'(busy), 1);
                chk({tag, ".key_ready"}, 32'(key_ready), 0);
            end
        end
    endtask

    // Answers in the first WAIT cycle and checks the captured outcome.
    task automatic respond(input string tag, input launch_t l);
        logic [7:0] r;
        logic e;
        alu_model(l, r, e);
        @(negedge clk);
        chk({tag, ".start_pulse"}, 32'(alu_start), 0);
        chk({tag, ".wait"}, 32'(state_dbg), 3);
        alu_done   = 1'b1;
        alu_result = r;
        alu_err    = e;
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        alu_err  = 1'b0;
        @(negedge clk);
        if (e) begin
            chk_st({tag, ".aluerr"}, 5, 0, 0);
            chk({tag, ".err_code"}, 32'(err_code), 2);
            chk({tag, ".err"}, 32'(err), 1);
        end else begin
            chk_st({tag, ".show"}, 4, 1, int'(r));
            chk({tag, ".busy"}, 32'(busy), 0);
        end
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 4'd0;
        alu_done = 1'b0; alu_result = 8'd0; alu_err = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        chk_st("reset", 0, 0, 0);
        chk("reset.key_ready", 32'(key_ready), 1);
        chk("reset.busy", 32'(busy), 0);
        chk("reset.err", 32'(err), 0);
        chk("reset.err_code", 32'(err_code), 0);
        chk("reset.start", 32'(alu_start), 0);
        chk("reset.op", 32'(alu_op), 0);

        // 12 + 3 = 15
        press(4'd1); press(4'd2);
        @(negedge clk); chk_st("add.mirrorA", 0, 0, 12);
        press(4'd10); press(4'd3);
        @(negedge clk); chk_st("add.mirrorB", 1, 0, 3);
        exp_q.push_back('{a: 8'd12, b: 8'd3, op: 2'd0});
        press(4'd14);
        expect_launch("add", got);
        respond("add", got);

        // '-' right after reset, then chained '*'
        do_reset();
        press(4'd11); press(4'd5);
        exp_q.push_back('{a: 8'd0, b: 8'd5, op: 2'd1});
        press(4'd14);
        expect_launch("sub0", got);
        respond("sub0", got);
        press(4'd12); press(4'd3);
        exp_q.push_back('{a: 8'd251, b: 8'd3, op: 2'd2});
        press(4'd14);
        expect_launch("chain", got);
        respond("chain", got);
        chk("chain.key_ready", 32'(key_ready), 1);

        // Entry overflow: 256
        press(4'd15);
        press(4'd2); press(4'd5); press(4'd6);
        @(negedge clk);
        chk_st("ovf", 5, 0, 0);
        chk("ovf.err_code", 32'(err_code), 1);
        chk("ovf.key_ready", 32'(key_ready), 1);
        press(4'd5);
        @(negedge clk);
        chk("ovf.ignore.state", 32'(state_dbg), 5);
        chk("ovf.ignore.code", 32'(err_code), 1);
        press(4'd15);
        @(negedge clk);
        chk_st("ovf.clear", 0, 0, 0);
        chk("ovf.clear.err", 32'(err), 0);
        chk("ovf.clear.code", 32'(err_code), 0);

        // 255 is the largest legal entry
        press(4'd2); press(4'd5); press(4'd5);
        @(negedge clk);
        chk_st("max255", 0, 0, 255);
        press(4'd15);

        // Divide by zero
        press(4'd8); press(4'd13); press(4'd0);
        exp_q.push_back('{a: 8'd8, b: 8'd0, op: 2'd3});
        press(4'd14);
        expect_launch("div0", got);
        respond("div0", got);

        // Reset during WAIT; late done ignored
        press(4'd15);
        press(4'd7); press(4'd10); press(4'd1);
        exp_q.push_back('{a: 8'd7, b: 8'd1, op: 2'd0});
        press(4'd14);
        expect_launch("rstwait", got);
        @(negedge clk);
        chk("rstwait.wait", 32'(state_dbg), 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_st("rstwait.after", 0, 0, 0);
        chk("rstwait.busy", 32'(busy), 0);
        alu_done = 1'b1; alu_result = 8'd77;
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        @(negedge clk);
        chk_st("rstwait.late_done", 0, 0, 0);

        // Operator replacement before B digits: 4 - 6
        press(4'd4); press(4'd10); press(4'd11); press(4'd6);
        exp_q.push_back('{a: 8'd4, b: 8'd6, op: 2'd1});
        press(4'd14);
        expect_launch("replop", got);
        respond("replop", got);

        // Operator after B digits dropped; done in LAUNCH ignored; key held in WAIT
        press(4'd15);
        press(4'd4); press(4'd10); press(4'd6); press(4'd12);
        @(negedge clk);
        chk("dropop.state", 32'(state_dbg), 1);
        chk("dropop.op", 32'(alu_op), 0);
        chk("dropop.b", 32'(result), 6);
        exp_q.push_back('{a: 8'd4, b: 8'd6, op: 2'd0});
        press(4'd14);
        expect_launch("hold", got);
        alu_done = 1'b1; alu_result = 8'd99;
        key_valid = 1'b1; key_code = 4'd9;
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold.wait", 32'(state_dbg), 3);
            chk("hold.key_ready", 32'(key_ready), 0);
        end
        alu_done = 1'b1; alu_result = 8'd10;
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        @(negedge clk);
        chk_st("hold.show", 4, 1, 10);
        chk("hold.key_ready_show", 32'(key_ready), 1);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        @(negedge clk);
        chk_st("hold.digit_from_show", 0, 0, 9);

        // '=' in ENTER_A shows A without the ALU
        press(4'd15);
        press(4'd4); press(4'd2); press(4'd14);
        @(negedge clk);
        chk_st("eqA", 4, 1, 42);
        chk("eqA.start", 32'(alu_start), 0);
        chk("eqA.busy", 32'(busy), 0);
        press(4'd14);
        @(negedge clk);
        chk_st("eqA.eq_in_show", 4, 1, 42);

        // No alu_done after launch
        press(4'd15);
        press(4'd1); press(4'd10); press(4'd1);
        exp_q.push_back('{a: 8'd1, b: 8'd1, op: 2'd0});
        press(4'd14);
        expect_launch("tmo", got);
`ifdef CALC_SEQ_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("tmo.still_wait", 32'(state_dbg), 3);
        end
        @(negedge clk);
        chk_st("tmo.error", 5, 0, 0);
        chk("tmo.err_code", 32'(err_code), 3);
`else
        for (int i = 0; i < 100; i++) @(negedge clk);
        chk("notmo.wait", 32'(state_dbg), 3);
        chk("notmo.busy", 32'(busy), 1);
        chk("notmo.err_code", 32'(err_code), 0);
`endif
        do_reset();
        @(negedge clk);
        chk_st("final_reset", 0, 0, 0);
        chk("final.sb_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
Key-entry controller that sequences the calculator ALU datapath. It accepts 4-bit key codes (digits and operators) from the ui_in[3:0] path and builds two decimal operands and an opcode. It then launches the ALU with a start/done handshake, captures the result or the error, and holds it for the output mux. It sits between the input pins and the ALU inside the tt_um top.

Parameters:
WIDTH, 8, operand/result width in bits
TIMEOUT_CYC, 15, max WAIT cycles before timeout error (used only with CALC_SEQ_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
key_valid  input  1  key_code valid this cycle
key_code  input  4  0-9 digit, 10 '+', 11 '-', 12 '*', 13 '/', 14 '=', 15 clear
key_ready  output  1  key accepted when key_valid && key_ready
alu_start  output  1  one-cycle launch pulse
alu_op  output  2  0 add, 1 sub, 2 mul, 3 div
alu_a  output  WIDTH  operand A
alu_b  output  WIDTH  operand B
alu_done  input  1  ALU result valid (one-cycle pulse)
alu_result  input  WIDTH  ALU result, sampled with alu_done
alu_err  input  1  ALU error (div by zero, overflow), sampled with alu_done
result  output  WIDTH  displayed value
result_valid  output  1  result holds a completed computation
err  output  1  sequencer in ERROR
err_code  output  2  0 none, 1 entry overflow, 2 ALU error, 3 timeout
busy  output  1  high in LAUNCH and WAIT
state_dbg  output  3  current state encoding

Behaviour:
- Clock and reset: clk only. Reset is synchronous and active-high on rst. Reset applies in any state, including mid-WAIT, and abandons the ALU operation. Any late alu_done after reset is ignored.
- Reset values: state ENTER_A, all registers 0, alu_start 0, alu_op 0, key_ready 1, result_valid 0, err 0, err_code 0, busy 0.
- States: ENTER_A=0, ENTER_B=1, LAUNCH=2, WAIT=3, SHOW=4, ERROR=5.
- key_ready: 1 in ENTER_A, ENTER_B, SHOW and ERROR; 0 in LAUNCH and WAIT. Keys offered while key_ready=0 are not consumed.
- Digit entry in ENTER_A/ENTER_B: acc <= acc*10 + d, computed at WIDTH+4 bits.
  - If the value exceeds 2^WIDTH-1: go to ERROR with err_code=1.
  - No digit-count limit.
- ENTER_A:
  - digit: accumulates into A.
  - operator: latches op, clears B and b_seen, goes to ENTER_B.
  - '=': result <= A, result_valid <= 1, goes to SHOW, ALU not started.
  - clear: zeroes A, stays in ENTER_A.
- ENTER_B:
  - digit: accumulates into B and sets b_seen.
  - operator with b_seen=0: replaces op.
  - operator with b_seen=1: dropped (consumed, no effect).
  - '=': goes to LAUNCH. If b_seen=0 then B=0.
  - clear: goes to ENTER_A with everything zeroed.
- LAUNCH (1 cycle): alu_start=1; alu_a, alu_b and alu_op are driven; next state WAIT. alu_a, alu_b and alu_op stay stable from LAUNCH until WAIT exits.
- WAIT: alu_done is sampled only in WAIT, so a done in the LAUNCH cycle is ignored.
  - On alu_done with alu_err=0: result <= alu_result, result_valid <= 1, goes to SHOW.
  - On alu_done with alu_err=1: goes to ERROR with err_code=2.
- Latency: '=' accepted in cycle N gives alu_start in N+1. alu_done sampled in cycle M gives result_valid=1 from M+1.
- SHOW:
  - operator: A <= result, op latched, result_valid <= 0, goes to ENTER_B (chaining).
  - digit: A <= digit, result_valid <= 0, goes to ENTER_A.
  - '=': no effect.
  - clear: goes to ENTER_A.
- ERROR: err=1, result=0, result_valid=0. Only clear is acted on (goes to ENTER_A, err_code=0). All other keys are consumed and dropped.
- In ENTER states, result mirrors the operand being entered (A or B) and result_valid=0.
- busy=1 exactly in LAUNCH and WAIT.

Optional Feature:
- Macro: CALC_SEQ_TIMEOUT_EN.
- Defined: a WAIT cycle counter resets on WAIT entry. If alu_done has not arrived after TIMEOUT_CYC cycles in WAIT, go to ERROR with err_code=3.
- Not defined: no counter; WAIT waits indefinitely for alu_done and err_code 3 is never produced.

Test Plan:
- Keys 1,2,'+',3,'=' -> alu_start pulse with alu_a=12, alu_b=3, alu_op=0. ALU returns done with result 15 -> result=15, result_valid=1, state SHOW.
- Keys 11('-') after reset, 5, '=' -> alu_a=0, alu_b=5, alu_op=1. Then in SHOW keys 12('*'),3,'=' -> alu_a=previous result, alu_b=3, alu_op=2 (chaining).
- With WIDTH=8, keys 2,5,6 -> ERROR, err_code=1, key_ready=1. Key 5 -> ignored. Key 15 -> ENTER_A, err=0.
- Keys 8,'/',0,'=' and ALU returns alu_err=1 -> err_code=2, result_valid=0. Assert rst during a later WAIT -> next cycle ENTER_A, busy=0, late alu_done ignored.
- Keys 4,'+','-',6,'=' -> alu_op=1, alu_b=6. Keys 4,'+',6,'*' -> '*' dropped, op stays 0. key_valid held during WAIT -> key not consumed until SHOW.
- With CALC_SEQ_TIMEOUT_EN and TIMEOUT_CYC=15, no alu_done after launch -> ERROR with err_code=3 after 15 WAIT cycles. Without the macro -> still in WAIT after 100 cycles.
